i2c_master_wr: RTL and testbench

I2C_MASTER_WR -- requirements
Module: i2c_master_wr

---
 rtl/i2c_master_wr.sv | 186 ++++++++++++++++++
 tb/tb_i2c_master_wr.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_wr.sv
// i2c_master_wr -- write-only I2C bus master.
//
// One command writes a single address byte ({addr, 0}) followed by a stream
// of data bytes, all MSB first. Each bit is four quarters of CLK_DIV clocks:
// SCL is low for Q0/Q1 and released for Q2/Q3, and SDA changes at the start
// of Q0. A NACK from the slave ends the transfer with a STOP.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o   start request; accepted only while idle
//   cmd_addr_i[6:0]           7-bit slave address, latched on acceptance
//   tx_valid_i/tx_ready_o     data byte handshake (ready pulses once per byte)
//   tx_data_i[7:0], tx_last_i byte to send and final-byte flag
//   scl_i, sda_i              sensed bus levels
//   scl_o, sda_o              open-drain drive (0 = pull low, 1 = release)
//   busy_o                    high whenever not idle
//   done_o                    one-cycle pulse when the transfer has ended
//   nack_o                    sticky NACK flag, cleared by the next command
//
// Optional build macro I2C_MASTER_CLK_STRETCH_EN: when defined, the Q2 quarter
// counter freezes while a slave holds SCL low (clock stretching). When not
// defined, scl_i is ignored and bit timing is free-running.
module i2c_master_wr #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [6:0] cmd_addr_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_o
);

  localparam logic [9:0] QMAX = 10'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA_WAIT, S_DATA, S_DATA_ACK, S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [9:0]  r_qcnt;
  logic [1:0]  r_quarter;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_last;
  logic        r_nack;
  logic        r_done;

  logic w_timed, w_bit_state, w_ack_state, w_shift_state;
  logic w_stretch, w_qend, w_bit_end, w_sample;

  // Quarter timing runs in every state except IDLE and DATA_WAIT.
  assign w_timed       = (r_state != S_IDLE) && (r_state != S_DATA_WAIT);
  assign w_ack_state   = (r_state == S_ADDR_ACK) || (r_state == S_DATA_ACK);
  assign w_shift_state = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_bit_state   = w_ack_state || w_shift_state;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // SCL has been released for Q2; hold the count until the line really rises.
  assign w_stretch = w_bit_state && (r_quarter == 2'd2) && !scl_i;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
  assign w_stretch    = 1'b0;
`endif

  assign w_qend    = w_timed && !w_stretch && (r_qcnt == QMAX);
  assign w_bit_end = w_qend && (r_quarter == 2'd3);
  // Ack is sampled on the last clock of Q2, i.e. mid SCL-high.
  assign w_sample  = w_ack_state && w_qend && (r_quarter == 2'd2);

  assign cmd_ready_o = (r_state == S_IDLE) && !rst;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign nack_o      = r_nack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qcnt    <= '0;
      r_quarter <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_last    <= 1'b0;
      r_nack    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_STOP) && w_bit_end;

      if (!w_timed) begin
        r_qcnt    <= '0;
        r_quarter <= '0;
      end else if (w_qend) begin
        r_qcnt    <= '0;
        r_quarter <= r_quarter + 2'd1;
      end else if (!w_stretch) begin
        r_qcnt <= r_qcnt + 10'd1;
      end

      if ((r_state == S_IDLE) && cmd_valid_i) begin
        r_shift <= {cmd_addr_i, 1'b0};
        r_bit   <= '0;
        r_nack  <= 1'b0;
      end else if ((r_state == S_DATA_WAIT) && tx_valid_i) begin
        r_shift <= tx_data_i;
        r_last  <= tx_last_i;
        r_bit   <= '0;
      end else if (w_shift_state && w_bit_end) begin
        r_shift <= {r_shift[6:0], 1'b0};
        r_bit   <= r_bit + 3'd1;
      end

      if (w_sample && sda_i) begin
        r_nack <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    scl_o        = 1'b1;
    sda_o        = 1'b1;
    tx_ready_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) w_state_next = S_START;
      end
      S_START: begin
        // SDA falls halfway through a fully released SCL period.
        sda_o = !r_quarter[1];
        if (w_bit_end) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        scl_o = r_quarter[1];
        sda_o = r_shift[7];
        if (w_bit_end && (r_bit == 3'd7)) w_state_next = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        scl_o = r_quarter[1];
        if (w_bit_end) w_state_next = r_nack ? S_STOP : S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        // Park the bus with both lines low until the next byte arrives.
        scl_o      = 1'b0;
        sda_o      = 1'b0;
        tx_ready_o = tx_valid_i;
        if (tx_valid_i) w_state_next = S_DATA;
      end
      S_DATA: begin
        scl_o = r_quarter[1];
        sda_o = r_shift[7];
        if (w_bit_end && (r_bit == 3'd7)) w_state_next = S_DATA_ACK;
      end
      S_DATA_ACK: begin
        scl_o = r_quarter[1];
        if (w_bit_end) w_state_next = (r_nack || r_last) ? S_STOP : S_DATA_WAIT;
      end
      S_STOP: begin
        // Q0 both low, Q1 SCL up, Q2/Q3 SDA up while SCL is high.
        scl_o = (r_quarter != 2'd0);
        sda_o = r_quarter[1];
        if (w_bit_end) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_wr.sv
// tb_i2c_master_wr -- self-checking bench for i2c_master_wr.
//
// A transfer-level model produces, cycle by cycle, the bus levels and status
// outputs the master must show, acting as the slave at the same time. A bus
// monitor counts SCL rises, START/STOP conditions and status pulses so that a
// few directed transfers can be pinned to hand-computed numbers.
module tb_i2c_master_wr;

  localparam int D = 4;
`ifdef I2C_MASTER_CLK_STRETCH_EN
  localparam int STRETCH_EXTRA = 50;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [6:0] cmd_addr;
  logic       tx_valid, tx_last, tx_ready;
  logic [7:0] tx_data;
  logic       scl_i, sda_i, scl_o, sda_o;
  logic       busy, done, nack;
  logic       slave_low, scl_hold;

  assign scl_i = scl_o & ~scl_hold;
  assign sda_i = sda_o & ~slave_low;

  always #5 clk = ~clk;

  i2c_master_wr #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .tx_valid_i(tx_valid), .tx_data_i(tx_data), .tx_last_i(tx_last), .tx_ready_o(tx_ready),
    .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o),
    .busy_o(busy), .done_o(done), .nack_o(nack)
  );

  // ---------------- bus monitor ----------------
  int          m_busy = 0, m_txr = 0, m_done = 0, m_rise = 0, m_start = 0, m_stop = 0;
  logic [63:0] m_bits = '0;
  logic        m_scl_prev = 1'b1, m_sda_prev = 1'b1;

  always @(negedge clk) begin
    if (scl_i && !m_scl_prev) begin
      m_bits <= {m_bits[62:0], sda_i};
      m_rise <= m_rise + 1;
    end
    if (scl_i && m_scl_prev && m_sda_prev && !sda_i) m_start <= m_start + 1;
    if (scl_i && m_scl_prev && !m_sda_prev && sda_i) m_stop <= m_stop + 1;
    if (busy) m_busy <= m_busy + 1;
    if (tx_ready) m_txr <= m_txr + 1;
    if (done) m_done <= m_done + 1;
    m_scl_prev <= scl_i;
    m_sda_prev <= sda_i;
  end

  int s_busy, s_txr, s_done, s_rise, s_start, s_stop;
  task automatic snap();
    s_busy = m_busy; s_txr = m_txr; s_done = m_done;
    s_rise = m_rise; s_start = m_start; s_stop = m_stop;
  endtask

  // ---------------- scoreboard ----------------
  int   n_vec = 0, n_miss = 0;
  logic exp_nack;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Compare one cycle of outputs at the falling edge, then move to just
  // after the next rising edge where the caller sets the next inputs.
  task automatic step(input logic e_scl, input logic e_sda, input logic e_busy,
                      input logic e_txr, input logic e_done, input string nm);
    logic [6:0] act, exp;
    @(negedge clk);
    exp = {e_scl, e_sda, e_busy, ~e_busy, e_txr, e_done, exp_nack};
    act = {scl_o, sda_o, busy, cmd_ready, tx_ready, done, nack};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: {scl,sda,busy,cmd_rdy,tx_rdy,done,nack} got %b expected %b",
               nm, $time, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Inputs the master must ignore outside their handshake windows.
  task automatic junk();
    cmd_valid = 1'($urandom);
    cmd_addr  = 7'($urandom);
    tx_valid  = 1'($urandom);
    tx_data   = 8'($urandom);
    tx_last   = 1'($urandom);
  endtask

  // One 4-quarter bit; ack bits have SDA released by the master and the
  // slave answering. hold > 0 makes the slave keep SCL low at Q2 start.
  task automatic send_bit(input logic b, input logic is_ack, input logic ack,
                          input int hold, input string nm);
    int extra;
    extra = (hold > 0) ? STRETCH_EXTRA : 0;
    for (int c = 0; c < 4 * D + extra; c++) begin
      junk();
      slave_low = is_ack & ack;
      scl_hold  = (hold > 0) && (c >= 2 * D) && (c < 2 * D + hold);
      if (is_ack && !ack && (c >= 3 * D)) exp_nack = 1'b1;
      step(c >= 2 * D, is_ack ? 1'b1 : b, 1'b1, 1'b0, 1'b0, nm);
    end
    slave_low = 1'b0;
    scl_hold  = 1'b0;
  endtask

  // ---------------- transfer description ----------------
  logic [6:0] t_addr;
  int         t_nb;
  logic [7:0] t_data [0:7];
  logic       t_ack_addr;
  logic       t_ack  [0:7];
  int         t_gap  [0:7];
  int         t_stretch_byte, t_rst_byte;

  task automatic clear_cfg();
    t_nb = 1; t_ack_addr = 1'b1; t_stretch_byte = -1; t_rst_byte = -1;
    for (int k = 0; k < 8; k++) begin
      t_ack[k] = 1'b1; t_gap[k] = 0; t_data[k] = 8'h00;
    end
  endtask

  task automatic do_reset();
    logic [6:0] act;
    rst = 1'b1;
    #1;
    act = {scl_o, sda_o, busy, cmd_ready, tx_ready, done, nack};
    check("async_reset_outputs", int'(act), int'(7'b1100000));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_nack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      junk(); cmd_valid = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "post_reset");
    end
  endtask

  task automatic run_xfer();
    logic [7:0] ab;
    int idle_n;
    ab = {t_addr, 1'b0};
    idle_n = $urandom_range(0, 2);
    for (int i = 0; i < idle_n; i++) begin
      junk(); cmd_valid = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "idle");
    end
    junk(); cmd_valid = 1'b1; cmd_addr = t_addr;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "handshake");
    exp_nack = 1'b0;
    for (int c = 0; c < 4 * D; c++) begin
      junk();
      step(1'b1, c < 2 * D, 1'b1, 1'b0, 1'b0, "start");
    end
    for (int i = 0; i < 8; i++) send_bit(ab[7 - i], 1'b0, 1'b0, 0, "addr");
    send_bit(1'b1, 1'b1, t_ack_addr, 0, "addr_ack");
    if (t_ack_addr) begin
      for (int k = 0; k < t_nb; k++) begin
        for (int g = 0; g < t_gap[k]; g++) begin
          junk(); tx_valid = 1'b0;
          step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "data_wait");
        end
        junk(); tx_valid = 1'b1; tx_data = t_data[k]; tx_last = (k == t_nb - 1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "tx_accept");
        for (int i = 0; i < 8; i++) begin
          if ((k == t_rst_byte) && (i == 4)) begin
            do_reset();
            return;
          end
          send_bit(t_data[k][7 - i], 1'b0, 1'b0,
                   ((k == t_stretch_byte) && (i == 4)) ? 50 : 0, "data");
        end
        send_bit(1'b1, 1'b1, t_ack[k], 0, "data_ack");
        if (!t_ack[k]) break;
      end
    end
    for (int c = 0; c < 4 * D; c++) begin
      junk();
      step(c >= D, c >= 2 * D, 1'b1, 1'b0, 1'b0, "stop");
    end
    junk(); cmd_valid = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "done");
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] act;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; tx_valid = 1'b0; tx_data = '0;
    tx_last = 1'b0; slave_low = 1'b0; scl_hold = 1'b0; exp_nack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    act = {scl_o, sda_o, busy, cmd_ready, tx_ready, done, nack};
    check("reset_state", int'(act), int'(7'b1100000));
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "idle_after_reset");

    // Single byte 0xA5 to 0x21, all ACKed.
    clear_cfg(); t_addr = 7'h21; t_data[0] = 8'hA5;
    snap(); run_xfer();
    check("t1_busy_cycles", m_busy - s_busy, 321);
    check("t1_tx_ready_pulses", m_txr - s_txr, 1);
    check("t1_done_pulses", m_done - s_done, 1);
    check("t1_scl_rises", m_rise - s_rise, 19);
    check("t1_addr_byte", int'(m_bits[18:11]), 8'h42);
    check("t1_data_byte", int'(m_bits[9:2]), 8'hA5);
    check("t1_ack_bits", int'({m_bits[10], m_bits[1], m_bits[0]}), 0);
    check("t1_start_stop", (m_start - s_start) * 10 + (m_stop - s_stop), 11);
    check("t1_nack", int'(nack), 0);

    // Address 0x22 never ACKed.
    clear_cfg(); t_addr = 7'h22; t_ack_addr = 1'b0;
    snap(); run_xfer();
    check("t2_busy_cycles", m_busy - s_busy, 176);
    check("t2_tx_ready_pulses", m_txr - s_txr, 0);
    check("t2_done_pulses", m_done - s_done, 1);
    check("t2_addr_byte", int'(m_bits[9:2]), 8'h44);
    check("t2_nack_bit", int'(m_bits[1]), 1);
    check("t2_nack", int'(nack), 1);

    // Three bytes, tx_valid withheld 100 cycles before byte 2.
    clear_cfg(); t_addr = 7'h35; t_nb = 3;
    t_data[0] = 8'h01; t_data[1] = 8'h02; t_data[2] = 8'h03; t_gap[1] = 100;
    snap(); run_xfer();
    check("t3_busy_cycles", m_busy - s_busy, 711);
    check("t3_tx_ready_pulses", m_txr - s_txr, 3);
    check("t3_last_byte", int'(m_bits[9:2]), 8'h03);

    // Slave NACKs the second of three bytes.
    clear_cfg(); t_addr = 7'h11; t_nb = 3;
    t_data[0] = 8'h01; t_data[1] = 8'h02; t_data[2] = 8'h03; t_ack[1] = 1'b0;
    snap(); run_xfer();
    check("t4_busy_cycles", m_busy - s_busy, 466);
    check("t4_tx_ready_pulses", m_txr - s_txr, 2);
    check("t4_nack", int'(nack), 1);
    clear_cfg(); t_addr = 7'h21; t_data[0] = 8'h3C;
    run_xfer();
    check("t4_nack_cleared", int'(nack), 0);

    // Slave stretches SCL on data bit 3.
    clear_cfg(); t_addr = 7'h50; t_data[0] = 8'h5A; t_stretch_byte = 0;
    snap(); run_xfer();
    check("t5_busy_cycles", m_busy - s_busy, 321 + STRETCH_EXTRA);

    // Reset during the 5th data bit, then a normal transfer.
    clear_cfg(); t_addr = 7'h0F; t_nb = 2; t_data[0] = 8'hF0; t_data[1] = 8'h0F; t_rst_byte = 0;
    snap(); run_xfer();
    check("t6_no_done", m_done - s_done, 0);
    clear_cfg(); t_addr = 7'h21; t_data[0] = 8'hA5;
    snap(); run_xfer();
    check("t6_recover_done", m_done - s_done, 1);
    check("t6_recover_busy", m_busy - s_busy, 321);

    // Randomized transfers.
    for (int n = 0; n < 25; n++) begin
      clear_cfg();
      t_addr = 7'($urandom);
      t_nb = $urandom_range(1, 4);
      t_ack_addr = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < 8; k++) begin
        t_data[k] = 8'($urandom);
        t_ack[k]  = ($urandom_range(0, 5) != 0);
        t_gap[k]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      end
      if ($urandom_range(0, 4) == 0) t_stretch_byte = $urandom_range(0, t_nb - 1);
      run_xfer();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
